// File: rtl/serial_add16_if.sv
// Operand/result handshake bundle for the slice-serial adder.
// Both sides use a valid/ready handshake; the adder sits on the slave side.
interface serial_add16_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_add16.sv
// Slice-serial adder: adds two W-bit operands four bits per clock and holds
// the result (sum, carry out, signed overflow) until the consumer takes it.
module serial_add16 #(
    parameter int N_SLICES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add16_if.slave   bus
);
    localparam int W     = 4 * N_SLICES;
    localparam int CNT_W = $clog2(N_SLICES) + 1;
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0]         a_sl_s [N_SLICES];
    logic [3:0]         b_sl_s [N_SLICES];
    logic [3:0]         sa_s;
    logic [3:0]         sb_s;
    logic [4:0]         slice_sum_s;
    logic               msb_cin_s;
    logic               last_slice_s;

    function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

    // Carry into the slice MSB: bit 3 of the sum of the lower three bits plus carry.
    function automatic logic msb_carry_in(input logic [3:0] x, input logic [3:0] y,
                                          input logic ci);
        return 1'(({1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci}) >> 3);
    endfunction

    for (genvar i = 0; i < N_SLICES; i++) begin : g_slice
        assign a_sl_s[i] = a_q[4*i +: 4];
        assign b_sl_s[i] = b_q[4*i +: 4];
    end

    assign sa_s         = a_sl_s[cnt_q[IDX_W-1:0]];
    assign sb_s         = b_sl_s[cnt_q[IDX_W-1:0]];
    assign slice_sum_s  = slice_add(sa_s, sb_s, carry_q);
    assign msb_cin_s    = msb_carry_in(sa_s, sb_s, carry_q);
    assign last_slice_s = (cnt_q == CNT_W'(N_SLICES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = bus.in_valid ? ST_ADD : ST_IDLE;
            ST_ADD:  state_d = last_slice_s ? ST_DONE : ST_ADD;
            ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and result outputs decoded from registers only.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.sum       = sum_q;
        bus.c_out     = c_out_q;
        bus.ovf       = ovf_q;
    end

    // Operand capture and one-slice-per-cycle datapath.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    a_d     = a_q;
                end
            end
            ST_ADD: begin
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = slice_sum_s[4];
                for (int i = 0; i < N_SLICES; i++) begin
                    sum_d[4*i +: 4] = (cnt_q == CNT_W'(i)) ? slice_sum_s[3:0] : sum_q[4*i +: 4];
                end
                if (last_slice_s) begin
                    c_out_d = slice_sum_s[4];
                    ovf_d   = msb_cin_s ^ slice_sum_s[4];
                end else begin
                    c_out_d = c_out_q;
                    ovf_d   = ovf_q;
                end
            end
            ST_DONE: begin
                sum_d = sum_q;
            end
            default: begin
                sum_d = sum_q;
            end
        endcase
    end

    // Datapath registers; the result is kept after returning to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_serial_add16.sv
// Directed and random checks of serial_add16 against a full-width reference
// model, with expected results queued at issue and compared at completion.
module tb_serial_add16;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add16_if #(.W(W)) bus ();

    serial_add16 #(.N_SLICES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        res_t         r;
        logic [W:0]   full;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum   = full[W-1:0];
        r.c_out = full[W];
        r.ovf   = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    // Offer an operand after 'gap' idle cycles; returns on the negedge after acceptance.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit push, input int gap);
        int cyc;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        if (push) sb_q.push_back(model(a, b, cin));
        @(negedge clk);
        // Garbage while busy must not disturb the result in progress.
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.c_in     = 1'($urandom_range(0, 1));
        bus.in_valid = 1'($urandom_range(0, 1));
    endtask

    // Wait for a result, compare with the scoreboard, stall 'hold' cycles, then accept.
    task automatic recv(input int hold);
        int   cyc;
        res_t exp;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid_wait", 32'(bus.out_valid), 32'd1);
        check("latency", 32'(cyc), 32'd4);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard: observed empty queue expected pending result");
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        check("sum", 32'(bus.sum), 32'(exp.sum));
        check("c_out", 32'(bus.c_out), 32'(exp.c_out));
        check("ovf", 32'(bus.ovf), 32'(exp.ovf));
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
            check("hold_res", {15'd0, bus.sum, bus.c_out}, {15'd0, exp.sum, exp.c_out});
            check("hold_ovf", 32'(bus.ovf), 32'(exp.ovf));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("back_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        check("sum_retained", 32'(bus.sum), 32'(exp.sum));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;

        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_flags", {30'd0, bus.c_out, bus.ovf}, 32'd0);
        repeat (2) @(negedge clk);

        // Operand offered on the very first edge after reset release.
        rst_n = 1'b1;
        send(16'h0000, 16'h0001, 1'b0, 1'b1, 0);
        recv(0);
        send(16'h0033, 16'h0033, 1'b0, 1'b1, 0);
        recv(0);
        send(16'h000F, 16'h0001, 1'b0, 1'b1, 1);
        recv(0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);
        recv(0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 0);
        recv(10);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0);
        recv(0);

        // Abort mid-add with the counter at 2.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_flags", {30'd0, bus.c_out, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus.out_valid), 32'd0);
        end
        send(16'h1234, 16'h4321, 1'b0, 1'b1, 0);
        recv(0);
        check("fresh_sum_5555", 32'(bus.sum), 32'h5555);

        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1,
                 int'($urandom_range(0, 3)));
            recv(int'($urandom_range(0, 3)));
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_add16.md
SERIAL_ADD16 -- requirements
Module: serial_add16

Interface
REQ-001 SHALL provide parameter N_SLICES, default 4: number of 4-bit slices; operand width W = 4*N_SLICES (16 at default).
REQ-002 SHALL provide port CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL provide port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port IN_VALID  input  1  operand set on A, B, C_IN is valid.
REQ-005 SHALL provide port IN_READY  output  1  block can accept an operand set.
REQ-006 SHALL provide port A  input  W  addend A, unsigned or two's complement.
REQ-007 SHALL provide port B  input  W  addend B.
REQ-008 SHALL provide port C_IN  input  1  carry into the least-significant slice.
REQ-009 SHALL provide port OUT_VALID  output  1  SUM, C_OUT and OVF hold a completed result.
REQ-010 SHALL provide port OUT_READY  input  1  consumer accepts the result.
REQ-011 SHALL provide port SUM  output  W  registered sum A+B+C_IN mod 2^W.
REQ-012 SHALL provide port C_OUT  output  1  carry out of bit W-1.
REQ-013 SHALL provide port OVF  output  1  two's-complement overflow: carry into bit W-1 XOR C_OUT.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-015 IN_READY SHALL be 1 only in IDLE; OUT_VALID SHALL be 1 only in DONE.
REQ-016 IDLE: on an edge with IN_VALID=1, the block SHALL capture A, B and C_IN into internal registers, clear the slice counter to 0, and enter ADD.
REQ-017 IDLE: with IN_VALID=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-018 ADD: each edge SHALL compute one 4-bit slice i (i = counter): {carry, SUM[4i+3:4i]} = A[4i+3:4i] + B[4i+3:4i] + carry register. The carry register SHALL start at captured C_IN.
REQ-019 ADD: the counter SHALL increment each edge. On the edge processing slice N_SLICES-1, the block SHALL write C_OUT and OVF and enter DONE.
REQ-020 Latency: if the operand is accepted at edge k, OUT_VALID SHALL first be 1 after edge k+N_SLICES (k+4 at default).
REQ-021 OVF SHALL use the carry into bit W-1, taken from bit 3 of the top-slice 5-bit addition of the lower 3 bits plus carry, XORed with the final carry.
REQ-022 DONE: SUM, C_OUT and OVF SHALL hold stable while OUT_READY=0, with no limit on duration.
REQ-023 DONE: on an edge with OUT_READY=1, the block SHALL enter IDLE. There SHALL be no same-cycle accept/present bypass, so minimum throughput is one result per N_SLICES+2 cycles.
REQ-024 SUM, C_OUT and OVF SHALL retain the last result after return to IDLE, until the next ADD overwrites slice 0.
REQ-025 Changes on A, B, C_IN or IN_VALID outside IDLE SHALL be ignored and SHALL NOT affect the result in progress.
REQ-026 Arithmetic SHALL be modulo 2^W with no saturation. The counter SHALL be ceil(log2(N_SLICES))+1 bits wide and SHALL never wrap inside ADD.

Reset
REQ-027 RST_N=0 SHALL force, immediately and without a clock edge: state=IDLE, IN_READY=1, OUT_VALID=0, SUM=0, C_OUT=0, OVF=0, counter=0, carry register=0, operand registers=0.
REQ-028 Reset asserted mid-ADD or mid-DONE SHALL abort the operation. No partial result SHALL ever be presented with OUT_VALID=1.
REQ-029 On the first rising edge after RST_N deasserts, the block SHALL behave as IDLE, so an operand with IN_VALID=1 is accepted on that edge.

Verification
REQ-030 A=0x0000, B=0x0001, C_IN=0, accepted at edge k -> OUT_VALID=1 after k+4, SUM=0x0001, C_OUT=0, OVF=0.
REQ-031 A=0x0033, B=0x0033, C_IN=0 -> SUM=0x0066, C_OUT=0, OVF=0. A=0x000F, B=0x0001, C_IN=0 -> SUM=0x0010, exercising the inter-slice carry.
REQ-032 A=0xFFFF, B=0x0001, C_IN=0 -> SUM=0x0000, C_OUT=1, OVF=0. A=0x7FFF, B=0x0001 -> SUM=0x8000, C_OUT=0, OVF=1. A=0xFFFF, B=0xFFFF, C_IN=1 -> SUM=0xFFFF, C_OUT=1.
REQ-033 Backpressure: hold OUT_READY=0 for 10 cycles in DONE while toggling A/B/IN_VALID -> IN_READY=0 and outputs stable throughout; OUT_READY=1 -> IDLE on next edge, and the next operand is accepted one edge later.
REQ-034 Assert RST_N=0 for one cycle during ADD (counter=2) -> outputs cleared asynchronously, OUT_VALID never rises for the aborted operand; a fresh operand 0x1234+0x4321 then yields SUM=0x5555.
REQ-035 Random regression of at least 1000 operand sets with random IN_VALID/OUT_READY gaps -> every result equals the reference A+B+C_IN, with results emitted in acceptance order.
